// File: rtl/sum8_pkg.sv
// Shared types and helpers for the mod-256 frame checksum unit.
package sum8_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sum8_state_t;

    // Saturating increment; sticks at all-ones.
    function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/add8.sv
// Combinational modular adder: carry is dropped, result wraps at 2^DATA_W.
module add8
    import sum8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    assign o_y = i_a + i_b;

endmodule

// File: rtl/sum8_frame_acc.sv
// Streaming frame checksum: accumulates byte beats mod 2^DATA_W and presents
// sum and saturating beat count on the last beat of each frame.
module sum8_frame_acc
    import sum8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    sum8_state_t       r_state, w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_sum;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_sat;

    logic              w_in_fire, w_out_fire, w_accum;
    logic [DATA_W-1:0] w_op_a, w_sum;
    logic [CNT_W-1:0]  w_cnt_base, w_cnt_nxt;
    logic              w_sat_nxt;

    assign w_accum    = (r_state == ACCUM);
    assign in_ready   = w_accum || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // A beat accepted in HOLD opens a new frame, so it starts from a zero base.
    assign w_op_a     = w_accum ? r_acc : '0;
    assign w_cnt_base = w_accum ? r_cnt : '0;
    assign w_cnt_nxt  = sat_inc(w_cnt_base);
    assign w_sat_nxt  = (w_accum && r_sat) || (w_cnt_base == '1);

    add8 #(.DATA_W(DATA_W)) u_add8 (
        .i_a (w_op_a),
        .i_b (in_data),
        .o_y (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_in_fire && in_last) w_state_nxt = HOLD;
            HOLD:    if (w_out_fire && !(w_in_fire && in_last)) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_out_fire) r_out_valid <= 1'b0;
            if (w_in_fire) begin
                if (in_last) begin
                    r_out_sum   <= w_sum;
                    r_out_count <= w_cnt_nxt;
                    r_out_sat   <= w_sat_nxt;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_sat       <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_nxt;
                    r_sat <= w_sat_nxt;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_sum8_frame_acc.sv
// Directed vector table, hand-written corner sequences and a randomized
// frame stream checked against a simple checksum model.
module tb_sum8_frame_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_sat;
    logic [7:0] out_sum, out_count;

    int total = 0;
    int bad   = 0;

    sum8_frame_acc #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ov, input logic [7:0] s,
                           input logic [7:0] c, input logic st);
        chk({nm, "_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, "_sum"},   32'(out_sum),   32'(s));
        chk({nm, "_count"}, 32'(out_count), 32'(c));
        chk({nm, "_sat"},   32'(out_sat),   32'(st));
    endtask

    task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic ordy);
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        @(posedge clk); #1;
    endtask

    task automatic sat_frame(input int n, input logic [7:0] es, input logic es_sat, input string nm);
        for (int i = 1; i <= n; i++) beat(1'b1, 8'h01, (i == n), 1'b1);
        chk_out(nm, 1'b1, es, 8'hFF, es_sat);
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_sum;
        logic [7:0] e_cnt;
        logic       e_sat;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic       st;
    } exp_t;
    exp_t q[$];

    logic       mon_en = 1'b0;
    logic       rnd_en = 1'b0;
    int         rcv = 0;
    logic       pend = 1'b0;
    logic [7:0] ps, pc;

    // Output-side scoreboard and hold-stability checker for the random phase.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_sum",   32'(out_sum),   32'(ps));
                chk("rnd_hold_count", 32'(out_count), 32'(pc));
            end
            if (out_valid && out_ready) begin
                chk("rnd_q_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rnd_sum",   32'(out_sum),   32'(e.s));
                    chk("rnd_count", 32'(out_count), 32'(e.c));
                    chk("rnd_sat",   32'(out_sat),   32'(e.st));
                    rcv++;
                end
            end
            pend = out_valid && !out_ready;
            ps   = out_sum;
            pc   = out_count;
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int   k;
        logic took;
        in_valid = 1'b1; in_data = d; in_last = l;
        k = 0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            k++;
        end while (!took && k < 2000);
        if (!took) begin
            total++; bad++;
            $display("FAIL rnd_beat_timeout actual=stalled required=accepted");
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 1'b1, 8'h60, 8'd3, 1'b0};
        tbl[3]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h60, 8'd3, 1'b0};
        tbl[4]  = '{1'b1, 8'h20, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[5]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[6]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[7]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[8]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[9]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'd2, 1'b0};
        tbl[10] = '{1'b1, 8'h7A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7A, 8'd1, 1'b0};
        tbl[11] = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7A, 8'd1, 1'b0};
        tbl[12] = '{1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7A, 8'd1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 8'd0, 1'b0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            in_valid = tbl[i].vld; in_data = tbl[i].data;
            in_last = tbl[i].last; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            @(posedge clk); #1;
            chk_out($sformatf("v%0d", i), tbl[i].e_ov, tbl[i].e_sum, tbl[i].e_cnt, tbl[i].e_sat);
        end

        // Reset mid-frame clears partial sum and stale outputs at once.
        beat(1'b1, 8'h55, 1'b0, 1'b1);
        beat(1'b1, 8'h66, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, 8'h00, 8'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(1'b1, 8'h01, 1'b1, 1'b1);
        chk_out("after_rst", 1'b1, 8'h01, 8'd1, 1'b0);

        // Reset while a result is held under backpressure.
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        chk_out("hold_pre_rst", 1'b1, 8'h01, 8'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("rst_hold", 1'b0, 8'h00, 8'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_hold_after_valid", 32'(out_valid), 32'd0);

        sat_frame(255, 8'hFF, 1'b0, "sat255");
        sat_frame(256, 8'h00, 1'b1, "sat256");
        sat_frame(300, 8'h2C, 1'b1, "sat300");
        beat(1'b0, 8'h00, 1'b0, 1'b1);
        chk("sat_drain_valid", 32'(out_valid), 32'd0);

        mon_en = 1'b1;
        rnd_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int         n;
            logic [7:0] bytes [8];
            exp_t       e;
            n = $urandom_range(1, 8);
            e.s = 8'h00;
            for (int b = 0; b < n; b++) begin
                bytes[b] = 8'($urandom);
                e.s = e.s + bytes[b];
            end
            e.c = 8'(n);
            e.st = 1'b0;
            q.push_back(e);
            for (int b = 0; b < n; b++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
                    @(posedge clk); #1;
                end
                send_beat(bytes[b], (b == n - 1));
            end
        end
        rnd_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
        for (int k = 0; k < 200 && rcv < 1000; k++) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("rnd_frames_received", 32'(rcv), 32'd1000);
        chk("rnd_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum8_frame_acc.md
# sum8_frame_acc

Streaming mod-256 frame checksum unit that drives the 8-bit modular adder stage and registers its result. Accepts byte beats over a valid/ready interface, keeps a running sum per frame, and on the frame's last beat presents the final checksum and beat count downstream. It is the sequential stage around the combinational adder: it feeds the adder both operands (running sum and incoming byte) and consumes its 8-bit result.

## Interface
- `DATA_W`, 8: operand/sum width; fixed at 8 to match the adder stage.
- `CNT_W`, 8: beat-counter width; the counter saturates at 2^CNT_W-1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  DATA_W  byte to accumulate.
- `in_last`  in  1  beat is the final one of its frame.
- `out_valid`  out  1  checksum result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  DATA_W  frame sum mod 2^DATA_W.
- `out_count`  out  CNT_W  beats in frame, saturating.
- `out_sat`  out  1  frame beat count saturated.

## Operation
- States: `ACCUM` (collecting beats) and `HOLD` (result presented). Reset state is `ACCUM`.
- Reset values: `acc`=0, `cnt`=0, `sat`=0, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0.
- An input beat transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- `in_ready` = (state==`ACCUM`) || (state==`HOLD` && `out_ready`). It is combinational from state and `out_ready` only, never from `in_valid`.
- `ACCUM`, beat accepted, `in_last`=0:
  - `acc` <= add8(`acc`, `in_data`), carry discarded.
  - `cnt` <= `cnt`+1, saturating at all-ones.
  - `sat` is set if `cnt` is already all-ones.
- `ACCUM`, beat accepted, `in_last`=1:
  - `out_sum` <= add8(`acc`, `in_data`).
  - `out_count` and `out_sat` take the incremented, saturating count.
  - `out_valid` <= 1; `acc`, `cnt`, `sat` cleared; go to `HOLD`.
- `HOLD`:
  - `out_*` remain stable until the result transfers.
  - On result transfer with no simultaneous input beat: `out_valid` <= 0, go to `ACCUM`.
  - On result transfer with a simultaneous input beat, the beat is the first of the next frame:
    - If it is not last, `acc` <= `in_data`, `cnt` <= 1, and the next state is `ACCUM`.
    - If it is also last, the new single-beat result loads (`out_sum`=`in_data`, `out_count`=1), `out_valid` stays 1, and the state stays `HOLD`.
- Single-beat frame (`in_last` on the first beat): `out_sum`=`in_data`, `out_count`=1.
- Zero-length frames do not exist; `in_last` always marks a real beat.
- Asserting `rst` mid-frame or in `HOLD` discards the partial sum and any pending result. All outputs return to their reset values immediately.
- Nothing is written when `in_valid`=0; `in_data` and `in_last` are ignored.

## Timing
- Latency: result visible on `out_*` the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle inside a frame. Back-to-back frames lose no cycles when `out_ready`=1 while in `HOLD`.
- `out_valid`, once high, stays high until the result transfers (AXI-style; never withdrawn).
- Under backpressure (`out_ready`=0 in `HOLD`), `in_ready`=0. Upstream must hold its beat.
- Adder path: `acc` and `in_data` feed the adder combinationally; the result lands in a register in the same cycle. There is no internal pipeline.

## Structure
- Package `sum8_pkg`:
  - `DATA_W` default constant.
  - State enum `sum8_state_t` {`ACCUM`, `HOLD`}.
  - A helper for saturating increment.
- Sub-module `add8`: purely combinational `a`+`b` mod 256, DATA_W in, DATA_W out, no carry out. One instance, shared by the `ACCUM` and `HOLD`-restart paths through an operand mux (`acc` or 0).

## Test plan
- Reset, then frame bytes 0x10, 0x20, 0x30 (last), with `out_ready`=1 → one cycle later `out_valid`=1, `out_sum`=0x60, `out_count`=3, `out_sat`=0.
- Wrap-around: frame 0xF0, 0x20 (last) → `out_sum`=0x10, `out_count`=2.
- Backpressure: `out_ready`=0 for 5 cycles after the result → `in_ready`=0 and `out_*` stable. Raise `out_ready` while a new 1-beat frame 0x7A (last) is offered → next cycle `out_sum`=0x7A, `out_count`=1, `out_valid` stays 1.
- Saturation: 300 beats of 0x01 with the last flagged on beat 300 → `out_sum`=0x2C, `out_count`=255, `out_sat`=1.
- Reset mid-frame after 0x55, 0x66 → all outputs 0. Next frame 0x01 (last) → `out_sum`=0x01, `out_count`=1.
- Random valid gaps and random `out_ready`, 1000 frames, checked against a reference model → every sum and count matches and no beat is lost or duplicated.
